// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALU codes and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_NONE drives alu_control to 000 in states that do not use the ALU.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_controller_alu_decoder.sv
// ALU decoder: maps alu_op and funct to alu_control; purely combinational.
// Flags unsupported funct values only when the funct field is being decoded.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);

  always_comb begin
    alu_control   = ALU_AND;
    illegal_funct = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: begin
            alu_control   = ALU_ADD;
            illegal_funct = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: Moore decode of state, plus pc_en/ir_write/illegal_op
// that also depend on mem_ready, zero and the decoded opcode/funct.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       pc_write, branch, illegal_dec, illegal_funct;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dest    = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_src      = PCSRC_ALU;
    alu_op      = ALUOP_NONE;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal_dec = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALUOP_ADD;
        case (op_code)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default: begin
            illegal_dec = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = (op_code == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      RTYPEEX: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        state_next = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write  = 1'b1;
        reg_dest   = 1'b1;
        state_next = FETCH;
      end
      BEQEX: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_ALUOUT;
        branch     = 1'b1;
        state_next = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      JEX: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // The decoder only flags funct when alu_op selects funct decode (RTYPEEX).
  mips_alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .illegal_funct (illegal_funct)
  );

  assign pc_en      = pc_write | (branch & zero);
  assign illegal_op = illegal_dec | illegal_funct;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboarded bench: each instruction is expanded into its expected per-cycle control words.
module tb_mips_mc_controller;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [5:0] op_code, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dest, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int vectors, miscompares;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk(clk), .arst_n(arst_n), .op_code(op_code), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_control(alu_control), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  function automatic logic [20:0] ex(logic [3:0] s, logic req, logic wr, logic io, logic irw,
                                     logic pce, logic rw, logic rd, logic m2r, logic sa,
                                     logic [1:0] sb, logic [1:0] ps, logic [2:0] alu, logic ill);
    return {s, req, wr, io, irw, pce, rw, rd, m2r, sa, sb, ps, alu, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("ctrl_state%0d", e[20:17]),
              {state_dbg, mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dest,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, illegal_op}, e);
      end
    end
  endtask

  // One clock cycle: inputs for this cycle plus the control word it must produce.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                     input logic zr, input logic [20:0] e);
    @(posedge clk);
    #1;
    op_code = op; funct = fn; mem_ready = mr; zero = zr;
    exp_q.push_back(e);
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int wf);
    repeat (wf) cyc(op, fn, 1'b0, rb(), ex(FETCH, 1,0,0,0,0,0,0,0,0, SRCB_FOUR, PCSRC_ALU, ALU_ADD, 0));
    cyc(op, fn, 1'b1, rb(), ex(FETCH, 1,0,0,1,1,0,0,0,0, SRCB_FOUR, PCSRC_ALU, ALU_ADD, 0));
    cyc(op, fn, rb(), rb(), ex(DECODE, 0,0,0,0,0,0,0,0,0, SRCB_IMM_SH2, PCSRC_ALU, ALU_ADD, !is_legal(op)));
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                          input int wm, input logic zb);
    logic [2:0] ac;
    logic bad;
    fetch_decode(op, fn, wf);
    if (op == OP_LW || op == OP_SW)
      cyc(op, fn, rb(), rb(), ex(MEMADR, 0,0,0,0,0,0,0,0,1, SRCB_IMM, PCSRC_ALU, ALU_ADD, 0));
    case (op)
      OP_LW: begin
        repeat (wm) cyc(op, fn, 1'b0, rb(), ex(MEMRD, 1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        cyc(op, fn, 1'b1, rb(), ex(MEMRD, 1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        cyc(op, fn, rb(), rb(), ex(MEMWB, 0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 0));
      end
      OP_SW: begin
        repeat (wm) cyc(op, fn, 1'b0, rb(), ex(MEMWR, 1,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        cyc(op, fn, 1'b1, rb(), ex(MEMWR, 1,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
      end
      OP_RTYPE: begin
        bad = 1'b0;
        case (fn)
          FN_ADD:  ac = 3'b010;
          FN_SUB:  ac = 3'b110;
          FN_AND:  ac = 3'b000;
          FN_OR:   ac = 3'b001;
          FN_SLT:  ac = 3'b111;
          default: begin ac = 3'b010; bad = 1'b1; end
        endcase
        cyc(op, fn, rb(), rb(), ex(RTYPEEX, 0,0,0,0,0,0,0,0,1, SRCB_REG, PCSRC_ALU, ac, bad));
        cyc(op, fn, rb(), rb(), ex(RTYPEWB, 0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 0));
      end
      OP_BEQ:
        cyc(op, fn, rb(), zb, ex(BEQEX, 0,0,0,0,zb,0,0,0,1, SRCB_REG, PCSRC_ALUOUT, ALU_SUB, 0));
      OP_ADDI: begin
        cyc(op, fn, rb(), rb(), ex(ADDIEX, 0,0,0,0,0,0,0,0,1, SRCB_IMM, PCSRC_ALU, ALU_ADD, 0));
        cyc(op, fn, rb(), rb(), ex(ADDIWB, 0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 0));
      end
      OP_J:
        cyc(op, fn, rb(), rb(), ex(JEX, 0,0,0,0,1,0,0,0,0, 2'b00, PCSRC_JUMP, 3'b000, 0));
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] op, fn;
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b000111};
    vectors = 0; miscompares = 0;
    arst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op_code = '0; funct = '0;
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
      end
    join_none

    #12;
    check("reset_state", {17'd0, state_dbg}, 21'd0);
    check("reset_writes", {19'd0, mem_write, reg_write}, 21'd0);
    check("reset_illegal", {20'd0, illegal_op}, 21'd0);
    #10 arst_n = 1'b1;

    do_instr(OP_LW, FN_ADD, 0, 0, 1'b0);
    do_instr(OP_SW, FN_ADD, 0, 3, 1'b0);
    do_instr(OP_BEQ, FN_ADD, 0, 0, 1'b1);
    do_instr(OP_BEQ, FN_ADD, 0, 0, 1'b0);
    do_instr(OP_RTYPE, FN_SUB, 1, 0, 1'b0);
    do_instr(6'b111111, FN_ADD, 0, 0, 1'b0);

    // Abandon a lw while it waits in MEMRD.
    fetch_decode(OP_LW, FN_ADD, 0);
    cyc(OP_LW, FN_ADD, rb(), rb(), ex(MEMADR, 0,0,0,0,0,0,0,0,1, SRCB_IMM, PCSRC_ALU, ALU_ADD, 0));
    cyc(OP_LW, FN_ADD, 1'b0, rb(), ex(MEMRD, 1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
    @(negedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check("midrst_state", {17'd0, state_dbg}, 21'd0);
    check("midrst_writes", {19'd0, mem_write, reg_write}, 21'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #2 arst_n = 1'b1;
    #1 check("post_rst_state", {17'd0, state_dbg}, 21'd0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      do_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
